i2c_codec_target: RTL

- Synthesizable I2C target (responder) that models the write side of the WM8731 codec control port.
- It is the other end of the I2C initializer's bus. It decodes 3-byte register writes (device address byte, then {reg[6:0], data[8]}, then data[7:0]) and presents each completed write as a one-cycle register-write strobe.
- It is oversampled on the system clock. Used in the audio-path bench and on-board as a bus monitor/checker for the codec init sequence.

---
 rtl/i2c_codec_target.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_codec_target.sv
// i2c_codec_target
//   I2C target modelling the write side of the WM8731 control port.
//   Decodes 3-byte register writes (addr byte, {reg[6:0], d[8]}, d[7:0])
//   and presents each completed write as a one-cycle strobe. SCL and SDA
//   are oversampled on i_clk, which must run at least 8x the SCL rate.
//
// Ports
//   i_clk, i_rst_n      system clock, async active-low reset
//   i_scl, i_sda        bus inputs (asynchronous to i_clk)
//   o_sda_oe            1 = pull SDA low (ACK)
//   o_reg_addr/_data    register address/data of the last completed write
//   o_reg_valid         one-cycle strobe, addr/data valid in the same cycle
//   o_busy              1 from START to STOP
//   o_err               one-cycle strobe on protocol error
//   i_rd_addr/o_rd_data shadow register read port
//
// Build option
//   I2C_CODEC_TARGET_SHADOW_EN: builds a 16x9 shadow register file fed by
//   the write strobe; without it o_rd_data is tied to 0.

module i2c_codec_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic [6:0] o_reg_addr,
    output logic [8:0] o_reg_data,
    output logic       o_reg_valid,
    output logic       o_busy,
    output logic       o_err,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_ADDR, HI, ACK_HI, LO, ACK_LO, IGNORE
    } state_e;

    // Synchronizers and edge detection; idle bus is high.
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, scl_edge, start, stop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i_scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i_sda};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    assign scl_edge = scl_rise | scl_fall;
    // An SDA edge coinciding with an SCL edge is treated as data, not as
    // a bus condition.
    assign start    = ~sda_s & sda_prev_q & scl_s & ~scl_edge;
    assign stop     = sda_s & ~sda_prev_q & scl_s & ~scl_edge;

    // Frame FSM
    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hi_q, hi_d;
    logic        byte_done_q, byte_done_d;   // 8 bits in, waiting for SCL fall
    logic        extra_q, extra_d;           // frame complete, further bytes are errors
    logic        err_done_q, err_done_d;     // extra-byte error already reported
    logic        sda_oe_q, sda_oe_d;
    logic [6:0]  reg_addr_q, reg_addr_d;
    logic [8:0]  reg_data_q, reg_data_d;
    logic        reg_valid_q, reg_valid_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            hi_q        <= '0;
            byte_done_q <= 1'b0;
            extra_q     <= 1'b0;
            err_done_q  <= 1'b0;
            sda_oe_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_data_q  <= '0;
            reg_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            hi_q        <= hi_d;
            byte_done_q <= byte_done_d;
            extra_q     <= extra_d;
            err_done_q  <= err_done_d;
            sda_oe_q    <= sda_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            reg_valid_q <= reg_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        hi_d        = hi_q;
        byte_done_d = byte_done_q;
        extra_d     = extra_q;
        err_done_d  = err_done_q;
        sda_oe_d    = sda_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        reg_valid_d = 1'b0;
        busy_d      = busy_q;
        err_d       = 1'b0;

        if (start) begin
            state_d     = ADDR;
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            extra_d     = 1'b0;
            err_done_d  = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b1;
        end else if (stop) begin
            state_d     = IDLE;
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            // Address was acked but the write never completed.
            if (state_q inside {HI, ACK_HI, LO}) err_d = 1'b1;
        end else begin
            if (scl_rise && (state_q inside {ADDR, HI, LO, IGNORE})) begin
                shift_d   = {shift_q[6:0], sda_s};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_done_d = (state_q != IGNORE);
                    if (state_q == IGNORE && extra_q && !err_done_q) begin
                        err_d      = 1'b1;
                        err_done_d = 1'b1;
                    end
                end
            end
            // Byte-complete and ACK transitions happen on SCL low so the
            // ACK level is set up before the 9th clock rises.
            if (scl_fall) begin
                unique case (state_q)
                    ADDR: if (byte_done_q) begin
                        byte_done_d = 1'b0;
                        if (shift_q == {DEV_ADDR, 1'b0}) begin
                            state_d  = ACK_ADDR;
                            sda_oe_d = 1'b1;
                        end else begin
                            state_d  = IGNORE;
                        end
                    end
                    HI: if (byte_done_q) begin
                        byte_done_d = 1'b0;
                        hi_d        = shift_q;
                        state_d     = ACK_HI;
                        sda_oe_d    = 1'b1;
                    end
                    LO: if (byte_done_q) begin
                        byte_done_d = 1'b0;
                        reg_addr_d  = hi_q[7:1];
                        reg_data_d  = {hi_q[0], shift_q};
                        reg_valid_d = 1'b1;
                        state_d     = ACK_LO;
                        sda_oe_d    = 1'b1;
                    end
                    ACK_ADDR: begin sda_oe_d = 1'b0; state_d = HI; end
                    ACK_HI:   begin sda_oe_d = 1'b0; state_d = LO; end
                    ACK_LO:   begin sda_oe_d = 1'b0; state_d = IGNORE; extra_d = 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    assign o_sda_oe    = sda_oe_q;
    assign o_reg_addr  = reg_addr_q;
    assign o_reg_data  = reg_data_q;
    assign o_reg_valid = reg_valid_q;
    assign o_busy      = busy_q;
    assign o_err       = err_q;

`ifdef I2C_CODEC_TARGET_SHADOW_EN
    // Shadow copy of the codec registers; a write to R15 (codec reset)
    // clears the whole file rather than storing data.
    logic [8:0] shadow_q [16];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 16; i++) shadow_q[i] <= '0;
        end else if (reg_valid_q) begin
            if (reg_addr_q == 7'h0F) begin
                for (int i = 0; i < 16; i++) shadow_q[i] <= '0;
            end else if (reg_addr_q[6:4] == 3'b000) begin
                shadow_q[reg_addr_q[3:0]] <= reg_data_q;
            end
        end
    end

    assign o_rd_data = shadow_q[i_rd_addr];
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^i_rd_addr;
    assign o_rd_data      = '0;
`endif

endmodule
